// File: rtl/dsp_wdata_channel_if.sv
// W-channel bundle for the write-data dispatcher: master beats in, per-slave beats out,
// plus the link to the head of the write-address dispatcher's outstanding queue.
interface dsp_wdata_channel_if #(
  parameter int SLV_AMT          = 2,
  parameter int DATA_WIDTH       = 32,
  parameter int TRANS_DATA_LEN_W = 3,
  parameter int SLV_ID_W         = $clog2(SLV_AMT)
);
  logic [DATA_WIDTH-1:0]         m_WDATA_i;
  logic                          m_WLAST_i;
  logic                          m_WVALID_i;
  logic                          m_WREADY_o;
  logic [SLV_ID_W-1:0]           dsp_WADDR_slv_id_i;
  logic                          dsp_WADDR_disable_i;
  logic [TRANS_DATA_LEN_W-1:0]   dsp_WADDR_len_i;
  logic                          dsp_WADDR_shift_en_o;
  logic [DATA_WIDTH*SLV_AMT-1:0] sa_WDATA_o;
  logic [SLV_AMT-1:0]            sa_WLAST_o;
  logic [SLV_AMT-1:0]            sa_WVALID_o;
  logic [SLV_AMT-1:0]            sa_WREADY_i;
  logic                          wlast_err_o;

  // Dispatcher side: the block that owns the register slice.
  modport slave (
    input  m_WDATA_i, m_WLAST_i, m_WVALID_i,
    output m_WREADY_o,
    input  dsp_WADDR_slv_id_i, dsp_WADDR_disable_i, dsp_WADDR_len_i,
    output dsp_WADDR_shift_en_o,
    output sa_WDATA_o, sa_WLAST_o, sa_WVALID_o,
    input  sa_WREADY_i,
    output wlast_err_o
  );

  // Environment side: master, address dispatcher and slave arbiters.
  modport master (
    output m_WDATA_i, m_WLAST_i, m_WVALID_i,
    input  m_WREADY_o,
    output dsp_WADDR_slv_id_i, dsp_WADDR_disable_i, dsp_WADDR_len_i,
    input  dsp_WADDR_shift_en_o,
    input  sa_WDATA_o, sa_WLAST_o, sa_WVALID_o,
    output sa_WREADY_i,
    input  wlast_err_o
  );
endinterface

// File: rtl/dsp_wdata_channel.sv
// Per-master write-data dispatcher: routes W beats through a 1-entry slice to the slave
// named by the head outstanding write. Optional burst-length check: DSP_WDATA_LEN_CHECK_EN.
module dsp_wdata_channel #(
  parameter int SLV_AMT          = 2,
  parameter int DATA_WIDTH       = 32,
  parameter int TRANS_DATA_LEN_W = 3,
  parameter int SLV_ID_W         = $clog2(SLV_AMT)
) (
  input  logic                        ACLK_i,
  input  logic                        ARESET_i,
  dsp_wdata_channel_if.slave          bus,
  output logic [TRANS_DATA_LEN_W-1:0] dbg_beat_cnt
);

`ifdef DSP_WDATA_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  // Handshake rule on both sides: a beat moves on a cycle where valid and ready are both
  // high; a raised valid holds its payload stable until that cycle.
  logic                        slot_vld;
  logic                        slot_last;
  logic [DATA_WIDTH-1:0]       slot_data;
  logic [SLV_ID_W-1:0]         slot_id;
  logic [TRANS_DATA_LEN_W-1:0] beat_cnt;
  logic                        err_q;

  logic pop;
  logic wready;
  logic acc;
  logic cnt_at_len;
  logic len_err;
  logic burst_end;

  assign pop        = slot_vld & bus.sa_WREADY_i[slot_id];
  assign wready     = ~bus.dsp_WADDR_disable_i & (~slot_vld | pop);
  assign acc        = bus.m_WVALID_i & wready;
  assign cnt_at_len = (beat_cnt == bus.dsp_WADDR_len_i);

  // WLAST early, or the expected last beat arriving without WLAST.
  assign len_err    = LEN_CHECK & acc & (bus.m_WLAST_i ^ cnt_at_len);
  assign burst_end  = acc & (bus.m_WLAST_i | (LEN_CHECK & cnt_at_len));

  assign bus.m_WREADY_o           = wready;
  assign bus.dsp_WADDR_shift_en_o = acc & bus.m_WLAST_i;
  assign bus.wlast_err_o          = err_q;
  assign dbg_beat_cnt             = beat_cnt;

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      slot_vld  <= 1'b0;
      slot_last <= 1'b0;
      slot_data <= '0;
      slot_id   <= '0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (acc) begin
        slot_vld  <= 1'b1;
        slot_last <= bus.m_WLAST_i;
        slot_data <= bus.m_WDATA_i;
        slot_id   <= bus.dsp_WADDR_slv_id_i;
      end else if (pop) begin
        slot_vld  <= 1'b0;
      end

      if (burst_end) begin
        beat_cnt <= '0;
      end else if (acc) begin
        beat_cnt <= beat_cnt + TRANS_DATA_LEN_W'(1);
      end

      err_q <= len_err;
    end
  end

  // Only the selected slot sees the slice contents; every other slot is held at zero.
  always_comb begin
    bus.sa_WDATA_o  = '0;
    bus.sa_WLAST_o  = '0;
    bus.sa_WVALID_o = '0;
    for (int s = 0; s < SLV_AMT; s++) begin
      if (slot_id == SLV_ID_W'(s)) begin
        bus.sa_WDATA_o[s*DATA_WIDTH +: DATA_WIDTH] = slot_data;
        bus.sa_WLAST_o[s]                          = slot_last;
        bus.sa_WVALID_o[s]                         = slot_vld;
      end
    end
  end

endmodule
